// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_entry_t  : buffered {instruction, address} pair (default address width)
//   RESET_VECTOR   : PC value after reset
//   PC_READ_OFFSET : offset added to the head address for the architectural PC read
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;

    localparam logic [31:0] RESET_VECTOR   = 32'h0000_0000;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0]             instruction;
        logic [FETCH_ADDR_W-1:0] address;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry in-order buffer of fetched {instruction, address} entries.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   flush          : synchronous clear of all entries (wins over push/pop)
//   push/push_entry: append an entry (allowed when full if pop is also set)
//   pop            : retire the head entry
//   head/head_valid: head entry straight from the storage registers
//   count          : number of valid entries (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = fetch_entry_t,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  ENTRY_T           push_entry,
    input  logic             pop,
    output ENTRY_T           head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ENTRY_T           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation, request issue and response buffering for the
// instruction memory, with branch redirect and squashing of in-flight fetches.
// Ports:
//   clock, reset                  : rising-edge clock, asynchronous active-high reset
//   imem_address, imem_request    : word-aligned fetch request (accepted with imem_grant)
//   imem_grant                    : memory accepts the request this cycle
//   imem_valid, imem_rdata        : in-order read response
//   branch_taken, branch_target   : redirect to branch_target (low two bits ignored)
//   stall                         : consumer not ready
//   instruction, instruction_valid: head of the fetch buffer
//   pc_plus_8                     : head address + 8
// Optional build macro FETCH_PERF_COUNTERS_EN adds fetch_count and squash_count outputs.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_address,
    output logic              imem_request,
    input  logic              imem_grant,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic [31:0]       instruction,
    output logic              instruction_valid,
    output logic [ADDR_W-1:0] pc_plus_8
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       squash_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] SLOTS = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0]       instruction;
        logic [ADDR_W-1:0] address;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  squash;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] req_addr [DEPTH];
    logic [PTR_W-1:0]  req_wr;
    logic [PTR_W-1:0]  req_rd;
    logic              accepted;
    logic              response;
    logic              dropped;
    logic              push;
    logic              pop;
    logic              head_valid;
    entry_t            head;
    entry_t            push_entry;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Every request reserves a buffer slot, so a response can always be pushed.
    assign imem_request = !reset && !branch_taken &&
                          (({1'b0, outstanding} + {1'b0, fifo_count}) < SLOTS);
    assign imem_address = pc;

    assign accepted = imem_request && imem_grant;
    // A response with nothing outstanding (e.g. one that was in flight across reset) is ignored.
    assign response = imem_valid && (outstanding != '0);
    // Words fetched before a redirect are stale: those already counted in squash, and the
    // one arriving in the redirect cycle itself.
    assign dropped  = response && ((squash != '0) || branch_taken);
    assign push     = response && !dropped;
    assign pop      = head_valid && !stall && !branch_taken;

    assign push_entry.instruction = imem_rdata;
    assign push_entry.address     = req_addr[req_rd];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= ADDR_W'(RESET_VECTOR);
            outstanding <= '0;
            squash      <= '0;
            req_wr      <= '0;
            req_rd      <= '0;
        end else begin
            if (branch_taken) begin
                pc <= branch_target & ~ADDR_W'(3);
            end else if (accepted) begin
                pc <= pc + ADDR_W'(4);
            end

            case ({accepted, response})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (branch_taken) begin
                squash <= outstanding - CNT_W'(response);
            end else if (response && (squash != '0)) begin
                squash <= squash - CNT_W'(1);
            end

            // The address queue advances for every response, squashed or not, so it
            // stays aligned with the in-order response stream across redirects.
            if (accepted) begin
                req_wr <= ptr_next(req_wr);
            end
            if (response) begin
                req_rd <= ptr_next(req_rd);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accepted) begin
            req_addr[req_wr] <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (branch_taken),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign instruction       = head.instruction;
    assign instruction_valid = head_valid;
    assign pc_plus_8         = head.address + ADDR_W'(PC_READ_OFFSET);

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count  <= '0;
            squash_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            squash_count <= squash_count + 32'(dropped) +
                            (branch_taken ? 32'(fifo_count) : 32'd0);
        end
    end
`endif

`ifndef SYNTHESIS
    // Responses still in flight when reset hit may land during the first DEPTH cycles
    // after release; those are dropped silently. Later orphan responses are errors.
    logic [CNT_W-1:0] grace;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grace <= CNT_W'(DEPTH);
        end else if (grace != '0) begin
            grace <= grace - CNT_W'(1);
        end
    end

    orphan_response: assert property (@(posedge clock) disable iff (reset)
        imem_valid |-> ((outstanding != '0) || (grace != '0)));
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] imem_address;
    logic              imem_request;
    logic              imem_grant = 1'b0;
    logic              imem_valid = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              branch_taken = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic              stall = 1'b0;
    logic [31:0]       instruction;
    logic              instruction_valid;
    logic [ADDR_W-1:0] pc_plus_8;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]       fetch_count;
    logic [31:0]       squash_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    instruction_fetch #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .imem_address      (imem_address),
        .imem_request      (imem_request),
        .imem_grant        (imem_grant),
        .imem_valid        (imem_valid),
        .imem_rdata        (imem_rdata),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .stall             (stall),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .pc_plus_8         (pc_plus_8)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .fetch_count       (fetch_count),
        .squash_count      (squash_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic        grant;
        logic        valid;
        logic [31:0] rdata;
        logic        stall;
        logic        branch;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic        chk_head;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc8;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } os_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic vec_t mk(input int rst, input int g, input int v, input logic [31:0] rd,
                                input int st, input int br, input logic [31:0] tg,
                                input int er, input logic [31:0] ea, input int ei, input int ch,
                                input logic [31:0] einst, input logic [31:0] ep8);
        vec_t r;
        r.rst = (rst != 0);   r.grant = (g != 0);   r.valid = (v != 0);  r.rdata = rd;
        r.stall = (st != 0);  r.branch = (br != 0); r.target = tg;
        r.exp_req = (er != 0); r.exp_addr = ea; r.exp_iv = (ei != 0); r.chk_head = (ch != 0);
        r.exp_instr = einst;  r.exp_pc8 = ep8;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        @(negedge clock);
        reset         = v.rst;
        imem_grant    = v.grant;
        imem_valid    = v.valid;
        imem_rdata    = v.rdata;
        stall         = v.stall;
        branch_taken  = v.branch;
        branch_target = v.target;
        #1;
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_req"}, 32'(imem_request), 32'(v.exp_req));
        if (v.exp_req) chk({tag, "_addr"}, imem_address, v.exp_addr);
        chk({tag, "_ivalid"}, 32'(instruction_valid), 32'(v.exp_iv));
        if (v.chk_head) begin
            chk({tag, "_instr"}, instruction, v.exp_instr);
            chk({tag, "_pc8"}, pc_plus_8, v.exp_pc8);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        os_t         oq[$];
        pend_t       mq[$];
        logic [31:0] fq_i[$];
        logic [31:0] fq_a[$];
        logic [31:0] m_pc;
        os_t         e;
        logic        exp_req;
        logic        have_resp;
        logic [31:0] resp_data;

        // Reset row: outputs at their reset values while reset is held.
        // Sequential fetch, 1-cycle memory, no stall.
        vecs.push_back(mk(1,0,0,0,         0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(0),    0,0,0,       1,4,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(4),    0,0,0,       0,0,      1,1,dat(0),8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,8,      1,1,dat(4),12));
        vecs.push_back(mk(0,1,1,dat(8),    0,0,0,       1,12,     0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(12),   0,0,0,       0,0,      1,1,dat(8),16));
        // Stall held 5 cycles: two requests, buffer full, then in-order delivery.
        vecs.push_back(mk(1,0,0,0,         0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,1,0,0,         1,0,0,       1,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(0),    1,0,0,       1,4,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(4),    1,0,0,       0,0,      1,1,dat(0),8));
        vecs.push_back(mk(0,1,0,0,         1,0,0,       0,0,      1,1,dat(0),8));
        vecs.push_back(mk(0,1,0,0,         1,0,0,       0,0,      1,1,dat(0),8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       0,0,      1,1,dat(0),8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,8,      1,1,dat(4),12));
        // Redirect to 0x103 with two outstanding; both stale responses dropped.
        vecs.push_back(mk(1,0,0,0,         0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,0,      0,0,0,0));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,4,      0,0,0,0));
        vecs.push_back(mk(0,1,0,0,         0,1,'h103,   0,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(0),    0,0,0,       0,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(4),    0,0,0,       1,'h100,  0,0,0,0));
        vecs.push_back(mk(0,1,1,dat('h100),0,0,0,       1,'h104,  0,0,0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,       0,0,      1,1,dat('h100),'h108));
        // Redirect in the same cycle as a response and a pop.
        vecs.push_back(mk(1,0,0,0,         0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(0),    0,0,0,       1,4,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(4),    0,1,'h200,   0,0,      1,1,dat(0),8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,'h200,  0,0,0,0));
        vecs.push_back(mk(0,1,1,dat('h200),0,0,0,       1,'h204,  0,0,0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,       0,0,      1,1,dat('h200),'h208));
        // PC wrap from 0xFFFFFFFC.
        vecs.push_back(mk(1,0,0,0,         0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,0,0,0,         0,1,'hFFFFFFFF, 0,0,   0,0,0,0));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,'hFFFFFFFC, 0,0,0,0));
        vecs.push_back(mk(0,1,1,dat('hFFFFFFFC),0,0,0,  1,0,      0,0,0,0));
        vecs.push_back(mk(0,0,1,dat(0),    0,0,0,       0,0,      1,1,dat('hFFFFFFFC),4));
        vecs.push_back(mk(0,0,0,0,         0,0,0,       1,4,      1,1,dat(0),8));
        // Reset mid-stream with two outstanding; late responses ignored.
        vecs.push_back(mk(1,0,0,0,         0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,0,      0,0,0,0));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,4,      0,0,0,0));
        vecs.push_back(mk(1,1,1,'hBAD0,    0,0,0,       0,0,      0,1,0,8));
        vecs.push_back(mk(0,0,1,'hBAD1,    0,0,0,       1,0,      0,1,0,8));
        vecs.push_back(mk(0,0,1,'hBAD2,    0,0,0,       1,0,      0,1,0,8));
        vecs.push_back(mk(0,1,0,0,         0,0,0,       1,0,      0,0,0,0));
        vecs.push_back(mk(0,1,1,dat(0),    0,0,0,       1,4,      0,0,0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,       0,0,      1,1,dat(0),8));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

`ifdef FETCH_PERF_COUNTERS_EN
        chk("perf_fetch_after_restart", fetch_count, 32'd1);
        chk("perf_squash_after_restart", squash_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("perf_fetch_reset", fetch_count, 32'd0);
        chk("perf_squash_reset", squash_count, 32'd0);
`endif

        // Randomized run against a queue-based reference model.
        @(negedge clock);
        reset        = 1'b1;
        imem_grant   = 1'b0;
        imem_valid   = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        m_pc = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            reset         = 1'b0;
            imem_grant    = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom;
            have_resp     = (mq.size() > 0) && (mq[0].due <= cyc) && (oq.size() > 0);
            resp_data     = have_resp ? (mq[0].addr ^ 32'h5A5A_1234) : 32'h0;
            imem_valid    = have_resp;
            imem_rdata    = resp_data;
            if (have_resp) void'(mq.pop_front());
            #1;
            exp_req = !branch_taken && ((oq.size() + fq_i.size()) < DEPTH);
            chk("rnd_req", 32'(imem_request), 32'(exp_req));
            if (exp_req) chk("rnd_addr", imem_address, m_pc);
            chk("rnd_ivalid", 32'(instruction_valid), 32'(fq_i.size() > 0));
            if (fq_i.size() > 0) begin
                chk("rnd_instr", instruction, fq_i[0]);
                chk("rnd_pc8", pc_plus_8, fq_a[0] + 32'd8);
            end

            // Model the effect of the coming clock edge.
            e = '{addr: 32'h0, stale: 1'b1};
            if (have_resp) e = oq.pop_front();
            if (branch_taken) begin
                foreach (oq[k]) oq[k].stale = 1'b1;
                fq_i.delete();
                fq_a.delete();
                m_pc = branch_target & 32'hFFFF_FFFC;
            end else begin
                if ((fq_i.size() > 0) && !stall) begin
                    void'(fq_i.pop_front());
                    void'(fq_a.pop_front());
                end
                if (have_resp && !e.stale) begin
                    fq_i.push_back(resp_data);
                    fq_a.push_back(e.addr);
                end
                if (exp_req && imem_grant) begin
                    oq.push_back('{addr: m_pc, stale: 1'b0});
                    mq.push_back('{addr: m_pc, due: cyc + 1 + int'($urandom_range(0, 2))});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
